// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types and sizing helpers for the systolic feeder.
//               Holds the controller state encoding, the FEED/DRAIN window
//               lengths and the width of the skew index counter.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Controller states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } feeder_state_t;

    // Number of cycles needed to push every skewed operand into an N x N array
    function automatic int FEED_CYCLES(input int n);
        return 2 * n - 1;
    endfunction

    // Cycles the array needs after its last operand capture to settle
    function automatic int DRAIN_CYCLES(input int n);
        return n;
    endfunction

    // Counter width: wide enough for i + k and every FEED/DRAIN count
    // without wrapping
    function automatic int idx_width(input int n);
        return $clog2(3 * n) + 1;
    endfunction

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/operand_bank.sv
`default_nettype none
// ============================================================================
// Module      : operand_bank
// Description : N x N operand register file. One row is written per cycle;
//               all N*N elements are readable combinationally so the feeder
//               can pick any skewed element in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bank
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 16,
    parameter int DATA_SIZE   = 8,
    localparam int ROW_W      = $clog2(MATRIX_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ROW_W-1:0]     wr_row,
    input  logic [DATA_SIZE-1:0] wr_data [MATRIX_SIZE],
    output logic [DATA_SIZE-1:0] rd_data [MATRIX_SIZE][MATRIX_SIZE]
);

    logic [DATA_SIZE-1:0] r_mem [MATRIX_SIZE][MATRIX_SIZE];

    // One write decoder per row; an index of N or more matches no row and
    // the write is silently dropped.
    generate
        for (genvar r = 0; r < MATRIX_SIZE; r++) begin : g_row
            logic w_row_sel;
            assign w_row_sel = wr_en && (wr_row == ROW_W'(r));

            // Row storage: cleared on reset, loaded whole when selected
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < MATRIX_SIZE; k++) begin
                        r_mem[r][k] <= '0;
                    end
                end else if (w_row_sel) begin
                    for (int k = 0; k < MATRIX_SIZE; k++) begin
                        r_mem[r][k] <= wr_data[k];
                    end
                end
            end
        end
    endgenerate

    assign rd_data = r_mem;

endmodule : operand_bank
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Front-end controller for the systolic matrix_multiply array.
//               Stores operands A and B, and on start clears the array,
//               streams skewed A rows / B columns, waits for the pipeline to
//               drain and raises done after an exact cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 16,
    parameter int DATA_SIZE   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    input  logic                          load_is_b,
    input  logic [$clog2(MATRIX_SIZE)-1:0] load_row,
    input  logic [DATA_SIZE-1:0]          load_data [MATRIX_SIZE],
    input  logic                          start,
    output logic                          busy,
    output logic                          array_reset,
    output logic [DATA_SIZE-1:0]          feed_a [MATRIX_SIZE],
    output logic [DATA_SIZE-1:0]          feed_b [MATRIX_SIZE],
    output logic                          done
);

    localparam int CNT_W = idx_width(MATRIX_SIZE);

    // FEED ends on t = 2N-2. DRAIN counts 0..N: the array captures the last
    // operand one edge after it is presented, then needs N further edges
    // (N-1 hops plus the MAC register) before the result is final.
    localparam logic [CNT_W-1:0] c_FEED_LAST  = CNT_W'(FEED_CYCLES(MATRIX_SIZE) - 1);
    localparam logic [CNT_W-1:0] c_DRAIN_LAST = CNT_W'(DRAIN_CYCLES(MATRIX_SIZE));

    feeder_state_t        r_state;
    feeder_state_t        w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    logic                 w_load_ok;
    logic                 w_wr_a;
    logic                 w_wr_b;

    logic [DATA_SIZE-1:0] w_mat_a [MATRIX_SIZE][MATRIX_SIZE];
    logic [DATA_SIZE-1:0] w_mat_b [MATRIX_SIZE][MATRIX_SIZE];

    logic [DATA_SIZE-1:0] w_feed_a_nxt [MATRIX_SIZE];
    logic [DATA_SIZE-1:0] w_feed_b_nxt [MATRIX_SIZE];
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

    // Operands may only change while no multiply is in flight
    assign w_load_ok = load_valid && ((r_state == IDLE) || (r_state == DONE));
    assign w_wr_a    = w_load_ok && !load_is_b;
    assign w_wr_b    = w_load_ok &&  load_is_b;

    operand_bank #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_SIZE   (DATA_SIZE)
    ) u_bank_a (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_a),
        .wr_row  (load_row),
        .wr_data (load_data),
        .rd_data (w_mat_a)
    );

    operand_bank #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_SIZE   (DATA_SIZE)
    ) u_bank_b (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_b),
        .wr_row  (load_row),
        .wr_data (load_data),
        .rd_data (w_mat_b)
    );

    // Next-state and counter sequencing; start is ignored while busy
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                w_state_nxt = FEED;
                w_cnt_nxt   = '0;
            end
            FEED: begin
                if (r_cnt == c_FEED_LAST) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (r_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Skew decode for the upcoming cycle: lane i carries element k when
    // t == i + k, which is exactly the diagonal wavefront the array expects.
    always_comb begin
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            w_feed_a_nxt[i] = '0;
            w_feed_b_nxt[i] = '0;
        end
        if (w_state_nxt == FEED) begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                for (int k = 0; k < MATRIX_SIZE; k++) begin
                    if (w_cnt_nxt == CNT_W'(i + k)) begin
                        w_feed_a_nxt[i] = w_mat_a[i][k];
                        w_feed_b_nxt[i] = w_mat_b[k][i];
                    end
                end
            end
        end
    end

    assign w_busy_nxt = (w_state_nxt == CLEAR) || (w_state_nxt == FEED) ||
                        (w_state_nxt == DRAIN);
    assign w_done_nxt = (w_state_nxt == DONE);

    // Controller state plus outputs registered from the next-state decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                feed_a[i] <= '0;
                feed_b[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                feed_a[i] <= w_feed_a_nxt[i];
                feed_b[i] <= w_feed_b_nxt[i];
            end
        end
    end

    // Array clear follows reset asynchronously; the CLEAR term is taken from
    // the state register so start never reaches it combinationally.
    assign array_reset = reset | (r_state == CLEAR);

endmodule : systolic_feeder
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feeder
// Description : Self-checking bench for systolic_feeder (N=3, 8-bit data).
//               Operand matrices are mirrored in plain arrays; feeds are
//               predicted from the skew formula and the array result is
//               formed by a behavioural systolic sum of the captured feeds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int FC = 2 * N - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_is_b = 1'b0;
    logic [1:0]    load_row = 2'd0;
    logic [DW-1:0] load_data [N];
    logic          start = 1'b0;
    logic          busy;
    logic          array_reset;
    logic [DW-1:0] feed_a [N];
    logic [DW-1:0] feed_b [N];
    logic          done;

    systolic_feeder #(
        .MATRIX_SIZE (N),
        .DATA_SIZE   (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_is_b   (load_is_b),
        .load_row    (load_row),
        .load_data   (load_data),
        .start       (start),
        .busy        (busy),
        .array_reset (array_reset),
        .feed_a      (feed_a),
        .feed_b      (feed_b),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int ma [N][N];
    int mb [N][N];
    int hist_a [FC][N];
    int hist_b [FC][N];
    int res [N][N];

    typedef struct {
        int t;
        int ea [N];
        int eb [N];
    } skew_vec_t;

    skew_vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_a(input int i, input int t);
        if (t - i >= 0 && t - i < N) return ma[i][t - i];
        return 0;
    endfunction

    function automatic int exp_b(input int j, input int t);
        if (t - j >= 0 && t - j < N) return mb[t - j][j];
        return 0;
    endfunction

    function automatic int hist_a_at(input int i, input int t);
        if (t >= 0 && t < FC) return hist_a[t][i];
        return 0;
    endfunction

    function automatic int hist_b_at(input int j, input int t);
        if (t >= 0 && t < FC) return hist_b[t][j];
        return 0;
    endfunction

    // Drive one row write; the model takes it only when legal and in range
    task automatic set_load(input bit isb, input int row, input int v0,
                            input int v1, input int v2, input bit legal);
        load_valid   = 1'b1;
        load_is_b    = isb;
        load_row     = 2'(row);
        load_data[0] = DW'(v0);
        load_data[1] = DW'(v1);
        load_data[2] = DW'(v2);
        if (legal && row < N) begin
            if (isb) begin
                mb[row][0] = v0; mb[row][1] = v1; mb[row][2] = v2;
            end else begin
                ma[row][0] = v0; ma[row][1] = v1; ma[row][2] = v2;
            end
        end
    endtask

    task automatic do_load(input bit isb, input int row, input int v0,
                           input int v1, input int v2);
        set_load(isb, row, v0, v1, v2, 1'b1);
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic check_product(input string tag);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
                chk($sformatf("%s_c%0d%0d", tag, i, j), res[i][j], s);
            end
        end
    endtask

    // Caller has driven start (and any same-cycle load); this samples the
    // whole operation, checking feeds against the skew model each cycle.
    task automatic run_mult(input bit disturb);
        int lat;
        lat = -1;
        @(posedge clk); #1;
        start = 1'b0;
        load_valid = 1'b0;
        chk("clear_array_reset", int'(array_reset), 1);
        chk("clear_busy", int'(busy), 1);
        chk("clear_feed_a0", int'(feed_a[0]), 0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("feed_array_reset", int'(array_reset), 0);
            if (disturb && k == 3) load_valid = 1'b0;
            if (disturb && k == 3) start = 1'b0;
            if (disturb && k == 2) begin
                set_load(1'b0, 0, 9, 9, 9, 1'b0);
                start = 1'b1;
            end
            if (done) begin
                lat = k;
                break;
            end
            chk($sformatf("busy_k%0d", k), int'(busy), 1);
            for (int i = 0; i < N; i++) begin
                if (k <= FC) begin
                    hist_a[k - 1][i] = int'(feed_a[i]);
                    hist_b[k - 1][i] = int'(feed_b[i]);
                    chk($sformatf("feed_a%0d_t%0d", i, k - 1), int'(feed_a[i]), exp_a(i, k - 1));
                    chk($sformatf("feed_b%0d_t%0d", i, k - 1), int'(feed_b[i]), exp_b(i, k - 1));
                end else begin
                    chk($sformatf("drain_a%0d_k%0d", i, k), int'(feed_a[i]), 0);
                    chk($sformatf("drain_b%0d_k%0d", i, k), int'(feed_b[i]), 0);
                end
            end
        end
        chk("done_latency", lat, 3 * N + 1);
        chk("done_busy_low", int'(busy), 0);
        // Behavioural systolic array: PE(i,j) sees row i delayed j and
        // column j delayed i.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                res[i][j] = 0;
                for (int tau = 0; tau < 3 * N + 2; tau++) begin
                    res[i][j] += hist_a_at(i, tau - j) * hist_b_at(j, tau - i);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) load_data[k] = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 0;
                mb[i][j] = 0;
            end

        tbl[0] = '{t: 0, ea: '{1, 0, 0}, eb: '{1, 0, 0}};
        tbl[1] = '{t: 1, ea: '{2, 4, 0}, eb: '{0, 0, 0}};
        tbl[2] = '{t: 2, ea: '{3, 5, 7}, eb: '{0, 1, 0}};
        tbl[3] = '{t: 3, ea: '{0, 6, 8}, eb: '{0, 0, 0}};
        tbl[4] = '{t: 4, ea: '{0, 0, 9}, eb: '{0, 0, 1}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_array_reset", int'(array_reset), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_feed_a%0d", i), int'(feed_a[i]), 0);
            chk($sformatf("rst_feed_b%0d", i), int'(feed_b[i]), 0);
        end
        reset = 1'b0;
        #1;
        chk("idle_array_reset", int'(array_reset), 0);
        @(posedge clk); #1;

        // Skew: A = 1..9, B = identity
        do_load(1'b0, 0, 1, 2, 3);
        do_load(1'b0, 1, 4, 5, 6);
        do_load(1'b0, 2, 7, 8, 9);
        do_load(1'b1, 0, 1, 0, 0);
        do_load(1'b1, 1, 0, 1, 0);
        do_load(1'b1, 2, 0, 0, 1);
        start = 1'b1;
        run_mult(1'b0);
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("tbl_a%0d_t%0d", i, tbl[v].t), hist_a[tbl[v].t][i], tbl[v].ea[i]);
                chk($sformatf("tbl_b%0d_t%0d", i, tbl[v].t), hist_b[tbl[v].t][i], tbl[v].eb[i]);
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("e2e_c%0d%0d", i, j), res[i][j], 3 * i + j + 1);
        @(posedge clk); #1;
        chk("done_level", int'(done), 1);

        // Ignored start/load during FEED
        start = 1'b1;
        run_mult(1'b1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("ign_c%0d%0d", i, j), res[i][j], 3 * i + j + 1);

        // Back-to-back with same-cycle load of B row 1
        chk("done_array_reset", int'(array_reset), 0);
        set_load(1'b1, 1, 0, 2, 0, 1'b1);
        start = 1'b1;
        run_mult(1'b0);
        chk("b2b_c01", res[0][1], 4);
        chk("b2b_c11", res[1][1], 10);
        chk("b2b_c21", res[2][1], 16);
        check_product("b2b");

        // Reset during FEED
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_array_reset", int'(array_reset), 1);
        @(posedge clk); #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("midrst_feed_a%0d", i), int'(feed_a[i]), 0);
            chk($sformatf("midrst_feed_b%0d", i), int'(feed_b[i]), 0);
        end
        reset = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 0;
                mb[i][j] = 0;
            end
        @(posedge clk); #1;

        // Out-of-range row in IDLE
        do_load(1'b0, 3, 77, 77, 77);
        do_load(1'b1, 3, 55, 55, 55);
        chk("oor_no_x", int'($isunknown({busy, done, array_reset, feed_a[0], feed_a[1],
                                          feed_a[2], feed_b[0], feed_b[1], feed_b[2]})), 0);
        start = 1'b1;
        run_mult(1'b0);
        check_product("zero");

        // Randomized operands against the arithmetic product
        for (int r = 0; r < 4; r++) begin
            for (int row = 0; row < N; row++) begin
                do_load(1'b0, row, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)));
                do_load(1'b1, row, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)));
            end
            start = 1'b1;
            run_mult(1'b0);
            check_product($sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_systolic_feeder
`default_nettype wire
